// File: rtl/sargantana_icache_pkg.sv
// Shared types and sizing for the instruction-cache way-array refill path.
// Line, beat and set geometry plus the refill FSM state encoding.
package sargantana_icache_pkg;

    localparam int SET_WIDHT      = 256;
    localparam int ADDR_WIDHT     = 7;
    localparam int BEAT_WIDHT     = 64;
    localparam int NUM_WAYS       = 4;
    localparam int WAY_WIDHT      = $clog2(NUM_WAYS);
    localparam int BEATS_PER_SET  = SET_WIDHT / BEAT_WIDHT;
    localparam int BEAT_CNT_WIDHT =
        (BEATS_PER_SET > 1) ? $clog2(BEATS_PER_SET) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FLUSH
    } refill_state_t;

    function automatic logic [NUM_WAYS-1:0] way_onehot(
        input logic [WAY_WIDHT-1:0] way
    );
        logic [NUM_WAYS-1:0] v;
        v      = '0;
        v[way] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sargantana_icache_line_assembler.sv
// Collects refill beats into one full way line.
// Beat 0 lands in the LSBs; last_beat flags the final slot of the line.
module sargantana_icache_line_assembler
    import sargantana_icache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  beat_valid_i,
    input  logic [BEAT_WIDHT-1:0] beat_data_i,
    output logic [SET_WIDHT-1:0]  line_o,
    output logic                  last_beat_o
);

    logic [SET_WIDHT-1:0]      r_line;
    logic [BEAT_CNT_WIDHT-1:0] r_cnt;

    // Store each accepted beat at its slot and advance the slot pointer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_line <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_line <= '0;
            r_cnt  <= '0;
        end else if (beat_valid_i) begin
            r_line[r_cnt*BEAT_WIDHT +: BEAT_WIDHT] <= beat_data_i;
            r_cnt <= r_cnt + BEAT_CNT_WIDHT'(1);
        end
    end

    assign line_o      = r_line;
    assign last_beat_o = (r_cnt == BEAT_CNT_WIDHT'(BEATS_PER_SET - 1));

endmodule

// File: rtl/sargantana_icache_refill.sv
// Write-side driver for the icache way arrays: line refill and flush sweep.
// Way-array outputs decode only from registered state and datapath.
module sargantana_icache_refill
    import sargantana_icache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  fill_req_valid_i,
    output logic                  fill_req_ready_o,
    input  logic [ADDR_WIDHT-1:0] fill_addr_i,
    input  logic [WAY_WIDHT-1:0]  fill_way_i,
    input  logic                  beat_valid_i,
    input  logic [BEAT_WIDHT-1:0] beat_data_i,
    output logic                  beat_ready_o,
    input  logic                  kill_i,
    input  logic                  flush_i,
    output logic [NUM_WAYS-1:0]   way_req_o,
    output logic                  way_we_o,
    output logic [ADDR_WIDHT-1:0] way_addr_o,
    output logic [SET_WIDHT-1:0]  way_data_o,
    output logic                  arrays_busy_o,
    output logic                  fill_done_o,
    output logic                  flush_done_o
);

    refill_state_t r_state;
    refill_state_t w_next;

    logic [ADDR_WIDHT-1:0] r_addr;
    logic [WAY_WIDHT-1:0]  r_way;
    logic [ADDR_WIDHT-1:0] r_flush_cnt;
    logic                  r_pending;

    logic                 w_accept;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_flush_last;
    logic [SET_WIDHT-1:0] w_line;

    assign fill_req_ready_o = rstn_i & (r_state == IDLE)
                            & ~flush_i & ~r_pending;
    assign w_accept     = fill_req_valid_i & fill_req_ready_o;
    assign w_beat       = (r_state == FILL) & beat_valid_i & ~kill_i;
    assign w_flush_last = (r_state == FLUSH) & (r_flush_cnt == '1);

    sargantana_icache_line_assembler u_asm (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .clear_i      (w_accept),
        .beat_valid_i (w_beat),
        .beat_data_i  (beat_data_i),
        .line_o       (w_line),
        .last_beat_o  (w_last)
    );

    // Refill FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state: flush beats fill in IDLE, kill beats a beat in FILL
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (flush_i | r_pending) w_next = FLUSH;
                else if (w_accept)       w_next = FILL;
            end
            FILL: begin
                if (kill_i)               w_next = IDLE;
                else if (w_beat & w_last) w_next = WRITE;
            end
            WRITE:   w_next = IDLE;
            FLUSH:   if (w_flush_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture target set and victim way on request accept
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_addr <= '0;
            r_way  <= '0;
        end else if (w_accept) begin
            r_addr <= fill_addr_i;
            r_way  <= fill_way_i;
        end
    end

    // Sweep address: runs only in FLUSH, held at zero otherwise
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)               r_flush_cnt <= '0;
        else if (r_state == FLUSH) r_flush_cnt <= r_flush_cnt + ADDR_WIDHT'(1);
        else                       r_flush_cnt <= '0;
    end

    // Remember a flush that arrives while a fill owns the arrays
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_pending <= 1'b0;
        else if (w_flush_last)
            r_pending <= 1'b0;
        else if (flush_i & ((r_state == FILL) | (r_state == WRITE)))
            r_pending <= 1'b1;
    end

    // Way-array drive decoded from state; zeros when not writing
    always_comb begin
        way_req_o  = '0;
        way_we_o   = 1'b0;
        way_addr_o = '0;
        way_data_o = '0;
        unique case (r_state)
            WRITE: begin
                way_req_o  = way_onehot(r_way);
                way_we_o   = 1'b1;
                way_addr_o = r_addr;
                way_data_o = w_line;
            end
            FLUSH: begin
                way_req_o  = '1;
                way_we_o   = 1'b1;
                way_addr_o = r_flush_cnt;
            end
            default: ;
        endcase
    end

    assign beat_ready_o  = (r_state == FILL);
    assign arrays_busy_o = (r_state != IDLE);
    assign fill_done_o   = (r_state == WRITE);
    assign flush_done_o  = w_flush_last;

endmodule
